// File: rtl/mem_arb_pkg.sv
// +--------------------------------------------------------------------+
// | mem_arb_pkg : shared types for the two-requester memory arbiter    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

`default_nettype wire

// File: rtl/mem_rr_pick.sv
// +--------------------------------------------------------------------+
// | mem_rr_pick : two-way round-robin pick, valid vector -> one-hot    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  req_id_t            last,
  output logic [NUM_REQ-1:0] grant
);

  // On contention the requester that was not served last wins.
  always_comb begin
    grant = '0;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == 1'b1) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +--------------------------------------------------------------------+
// | mem_arbiter : round-robin front end of the single-port memory      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int WIDTH      = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_wr_rd,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [WIDTH-1:0]      r0_wdata,
  output logic [WIDTH-1:0]      r0_rdata,
  output logic                  r0_rvalid,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_wr_rd,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [WIDTH-1:0]      r1_wdata,
  output logic [WIDTH-1:0]      r1_rdata,
  output logic                  r1_rvalid,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_wr_rd,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0]      m_wdata,
  input  logic [WIDTH-1:0]      m_rdata,
  output logic                  err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                 r_state, w_state_nxt;
  req_id_t                r_last, r_owner;
  logic                   r_wr_rd;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [WIDTH-1:0]       r_wdata;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_err;
  logic [WIDTH-1:0]       r_rdata0, r_rdata1;

  logic [NUM_REQ-1:0]     w_valid, w_grant;
  logic                   w_idle, w_issue, w_accept, w_timeout, w_rd_done;
  req_id_t                w_gid;

  assign w_valid = {r1_valid, r0_valid};

  mem_rr_pick u_pick (
    .valid (w_valid),
    .last  (r_last),
    .grant (w_grant)
  );

  assign w_idle    = (r_state == IDLE);
  assign w_issue   = (r_state == ISSUE);
  assign w_accept  = w_idle && (|w_grant);
  assign w_gid     = req_id_t'(w_grant[1]);
  assign w_rd_done = w_issue && m_ready && !r_wr_rd;
  // Last wait cycle without m_ready: abort instead of waiting further.
  assign w_timeout = w_issue && !m_ready && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = ISSUE;
      ISSUE: begin
        if (m_ready)        w_state_nxt = r_wr_rd ? IDLE : RESP;
        else if (w_timeout) w_state_nxt = IDLE;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_wr_rd  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_timeout;
      if (w_accept) begin
        r_wr_rd <= w_gid ? r1_wr_rd : r0_wr_rd;
        r_addr  <= w_gid ? r1_addr  : r0_addr;
        r_wdata <= w_gid ? r1_wdata : r0_wdata;
        r_owner <= w_gid;
        r_last  <= w_gid;
        r_cnt   <= '0;
      end else if (w_issue && !m_ready) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_rd_done) begin
        if (r_owner) r_rdata1 <= m_rdata;
        else         r_rdata0 <= m_rdata;
      end
    end
  end

  assign r0_ready  = w_idle && w_grant[0];
  assign r1_ready  = w_idle && w_grant[1];
  assign r0_rvalid = (r_state == RESP) && (r_owner == 1'b0);
  assign r1_rvalid = (r_state == RESP) && (r_owner == 1'b1);
  assign r0_rdata  = r_rdata0;
  assign r1_rdata  = r_rdata1;

  // Memory sees nothing but zeros unless a transaction is in flight.
  assign m_valid = w_issue;
  assign m_wr_rd = w_issue && r_wr_rd;
  assign m_addr  = w_issue ? r_addr : '0;
  assign m_wdata = (w_issue && r_wr_rd) ? r_wdata : '0;
  assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_mem_arbiter : self-checking bench for mem_arbiter               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;

  localparam int TIMEOUT = 15;

  logic        clk, rst;
  logic        r0_valid, r0_ready, r0_wr_rd, r0_rvalid;
  logic [5:0]  r0_addr;
  logic [15:0] r0_wdata, r0_rdata;
  logic        r1_valid, r1_ready, r1_wr_rd, r1_rvalid;
  logic [5:0]  r1_addr;
  logic [15:0] r1_wdata, r1_rdata;
  logic        m_valid, m_ready, m_wr_rd, err;
  logic [5:0]  m_addr;
  logic [15:0] m_wdata, m_rdata;

  int n_checks, n_fail;

  // Reference state: round-robin pointer and each requester's last read data.
  bit          exp_last;
  logic [15:0] exp_rd0, exp_rd1;
  logic [15:0] mem_model [64];

  // Observations of one transaction, filled by drive_txn.
  bit          obs_acc, obs_stable, obs_rv_issue, obs_err;
  logic        obs_mv, obs_mwr, obs_mv_after;
  logic [5:0]  obs_maddr;
  logic [15:0] obs_mwd, obs_rd0, obs_rd1;
  logic [1:0]  obs_rv1, obs_rv2;

  mem_arbiter #(.ADDR_WIDTH(6), .WIDTH(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_wr_rd(r0_wr_rd), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_wr_rd(r1_wr_rd), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
    .m_valid(m_valid), .m_ready(m_ready), .m_wr_rd(m_wr_rd), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_req(input bit id, input bit v, input bit wr, input logic [5:0] a, input logic [15:0] d);
    if (id) begin r1_valid = v; r1_wr_rd = wr; r1_addr = a; r1_wdata = d; end
    else    begin r0_valid = v; r0_wr_rd = wr; r0_addr = a; r0_wdata = d; end
  endtask

  // Single requester transaction; the memory raises m_ready after lat wait cycles.
  // Entered shortly after a rising edge.
  task automatic drive_txn(input bit id, input bit wr, input logic [5:0] a, input logic [15:0] wd,
                           input logic [15:0] rd, input int lat);
    obs_acc = 0; obs_stable = 1; obs_rv_issue = 0; obs_err = 0;
    set_req(id, 1'b1, wr, a, wd);
    for (int t = 0; t < 20 && !obs_acc; t++) begin
      #1;
      if (id ? r1_ready : r0_ready) obs_acc = 1;
      obs_err |= err;
      @(posedge clk); #1;
    end
    set_req(id, 1'b0, 1'b0, 6'h0, 16'h0);
    if (!obs_acc) return;
    #1;
    obs_mv = m_valid; obs_mwr = m_wr_rd; obs_maddr = m_addr; obs_mwd = m_wdata;
    for (int k = 0; k <= lat; k++) begin
      if (k == lat) begin m_ready = 1'b1; m_rdata = rd; end
      #1;
      if ({m_valid, m_wr_rd, m_addr, m_wdata} !== {obs_mv, obs_mwr, obs_maddr, obs_mwd}) obs_stable = 0;
      obs_rv_issue |= (r0_rvalid | r1_rvalid);
      obs_err |= err;
      @(posedge clk); #1;
    end
    m_ready = 1'b0; m_rdata = 16'h0;
    #1;
    obs_rv1 = {r1_rvalid, r0_rvalid}; obs_mv_after = m_valid;
    obs_rd0 = r0_rdata; obs_rd1 = r1_rdata; obs_err |= err;
    @(posedge clk); #1;
    obs_rv2 = {r1_rvalid, r0_rvalid}; obs_err |= err;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({r0_ready, r1_ready, r0_rvalid, r1_rvalid, m_valid, m_wr_rd, m_addr, m_wdata, err, r0_rdata, r1_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got m_valid=%b m_addr=%h r0_rdata=%h r1_rdata=%h err=%b expected all zero",
                         m_valid, m_addr, r0_rdata, r1_rdata, err);
    end
    @(negedge clk) rst = 1'b1;
    exp_last = 1'b1; exp_rd0 = '0; exp_rd1 = '0;
    @(posedge clk); #1;
    drive_txn(1'b1, 1'b0, 6'h2A, 16'h0, 16'h1234, 1);
    exp_rd1 = 16'h1234; exp_last = 1'b1;
    n_checks++;
    if (obs_rd1 !== 16'h1234) begin n_fail++; $display("FAIL reset_preload_read: got %h expected 1234", obs_rd1); end
    // Start a write, then pull reset while it sits in ISSUE.
    set_req(1'b0, 1'b1, 1'b1, 6'h11, 16'hCAFE);
    #1;
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 6'h0, 16'h0);
    #1;
    n_checks++;
    if (m_valid !== 1'b1) begin n_fail++; $display("FAIL reset_pre_issue: m_valid got %b expected 1", m_valid); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({r0_ready, r1_ready, r0_rvalid, r1_rvalid, m_valid, m_wr_rd, m_addr, m_wdata, err, r0_rdata, r1_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_mid_issue: got m_valid=%b m_addr=%h m_wdata=%h r1_rdata=%h expected all zero",
                         m_valid, m_addr, m_wdata, r1_rdata);
    end
    exp_rd1 = '0; exp_last = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #2;
    n_checks++;
    if ({err, m_valid, r0_rvalid, r1_rvalid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_dropped_txn: err/m_valid/rvalid got %b%b%b%b expected 0000", err, m_valid, r0_rvalid, r1_rvalid);
    end
    set_req(1'b0, 1'b1, 1'b1, 6'h01, 16'h0101);
    set_req(1'b1, 1'b1, 1'b1, 6'h02, 16'h0202);
    #1;
    n_checks++;
    if ({r1_ready, r0_ready} !== 2'b01) begin n_fail++; $display("FAIL reset_first_grant: ready got %b expected 01", {r1_ready, r0_ready}); end
    exp_last = 1'b0;
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 6'h0, 16'h0);
    set_req(1'b1, 1'b0, 1'b0, 6'h0, 16'h0);
    #1;
    n_checks++;
    if ({m_valid, m_addr, m_wdata} !== {1'b1, 6'h01, 16'h0101}) begin
      n_fail++; $display("FAIL reset_first_issue: m_addr/m_wdata got %h/%h expected 01/0101", m_addr, m_wdata);
    end
    @(posedge clk); #1; m_ready = 1'b1;
    @(posedge clk); #1; m_ready = 1'b0;
  endtask

  task automatic test_single_write();
    drive_txn(1'b0, 1'b1, 6'h05, 16'hBEEF, 16'hDEAD, 1);
    exp_last = 1'b0;
    n_checks++;
    if (obs_acc !== 1'b1) begin n_fail++; $display("FAIL write_accept: got %b expected 1", obs_acc); end
    n_checks++;
    if ({obs_mv, obs_mwr, obs_maddr, obs_mwd} !== {1'b1, 1'b1, 6'h05, 16'hBEEF}) begin
      n_fail++; $display("FAIL write_issue: got v=%b wr=%b a=%h d=%h expected 1/1/05/beef", obs_mv, obs_mwr, obs_maddr, obs_mwd);
    end
    n_checks++;
    if ({obs_rv_issue, obs_rv1, obs_rv2, obs_mv_after, obs_err} !== 7'b0) begin
      n_fail++; $display("FAIL write_no_resp: rv=%b/%b/%b mv_after=%b err=%b expected zeros", obs_rv_issue, obs_rv1, obs_rv2, obs_mv_after, obs_err);
    end
    n_checks++;
    if ({obs_rd0, obs_rd1} !== {exp_rd0, exp_rd1}) begin
      n_fail++; $display("FAIL write_rdata_kept: got %h/%h expected %h/%h", obs_rd0, obs_rd1, exp_rd0, exp_rd1);
    end
  endtask

  task automatic test_single_read();
    drive_txn(1'b1, 1'b0, 6'h05, 16'h5555, 16'hBEEF, 1);
    exp_last = 1'b1; exp_rd1 = 16'hBEEF;
    n_checks++;
    if ({obs_acc, obs_mv, obs_mwr, obs_maddr, obs_mwd} !== {1'b1, 1'b1, 1'b0, 6'h05, 16'h0}) begin
      n_fail++; $display("FAIL read_issue: got acc=%b v=%b wr=%b a=%h d=%h expected 1/1/0/05/0000", obs_acc, obs_mv, obs_mwr, obs_maddr, obs_mwd);
    end
    n_checks++;
    if ({obs_rv_issue, obs_rv1, obs_rv2, obs_err} !== {1'b0, 2'b10, 2'b00, 1'b0}) begin
      n_fail++; $display("FAIL read_rvalid: got %b/%b/%b err=%b expected 0/10/00 err=0", obs_rv_issue, obs_rv1, obs_rv2, obs_err);
    end
    n_checks++;
    if ({obs_rd0, obs_rd1} !== {exp_rd0, exp_rd1}) begin
      n_fail++; $display("FAIL read_rdata: got %h/%h expected %h/%h", obs_rd0, obs_rd1, exp_rd0, exp_rd1);
    end
  endtask

  task automatic test_contention();
    bit          wr_c [2];
    logic [5:0]  a_c [2];
    logic [15:0] d_c [2];
    bit          reroll [2];
    int n_acc = 0, last_cyc = -1, age = 0, drain = 0;
    bit last_wr = 0, due = 0, due_id = 0, owner = 0, busy_acc = 0, spurious = 0, exp_id;
    logic [15:0] due_data = '0;
    for (int i = 0; i < 2; i++) begin
      wr_c[i] = 1'($urandom); a_c[i] = 6'($urandom); d_c[i] = 16'($urandom); reroll[i] = 0;
      set_req(i[0], 1'b1, wr_c[i], a_c[i], d_c[i]);
    end
    for (int cyc = 0; cyc < 300 && drain < 6; cyc++) begin
      if (due) begin
        n_checks++;
        if ({r1_rvalid, r0_rvalid} !== (due_id ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL contention_rvalid: got %b for owner %0d", {r1_rvalid, r0_rvalid}, due_id);
        end
        if (due_id) exp_rd1 = due_data; else exp_rd0 = due_data;
        n_checks++;
        if ({r0_rdata, r1_rdata} !== {exp_rd0, exp_rd1}) begin
          n_fail++; $display("FAIL contention_rdata: got %h/%h expected %h/%h", r0_rdata, r1_rdata, exp_rd0, exp_rd1);
        end
        due = 0;
      end else if (r0_rvalid || r1_rvalid) spurious = 1;
      if (m_valid) begin
        age++;
        m_ready = (age >= 2);
        m_rdata = 16'($urandom);
        if (m_ready && !m_wr_rd) begin due = 1; due_id = owner; due_data = m_rdata; end
      end else begin
        age = 0; m_ready = 1'b0;
      end
      #1;
      if ((r0_ready || r1_ready) && (m_valid || r0_rvalid || r1_rvalid)) busy_acc = 1;
      if (r0_ready || r1_ready) begin
        exp_id = !exp_last;
        n_checks++;
        if ({r1_ready, r0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL contention_grant_%0d: ready got %b expected requester %0d", n_acc, {r1_ready, r0_ready}, exp_id);
        end
        if (last_cyc >= 0) begin
          n_checks++;
          if (cyc - last_cyc != (last_wr ? 3 : 4)) begin
            n_fail++; $display("FAIL contention_spacing: got %0d cycles expected %0d", cyc - last_cyc, last_wr ? 3 : 4);
          end
        end
        last_cyc = cyc; last_wr = wr_c[exp_id]; owner = exp_id; exp_last = exp_id;
        n_acc++; reroll[exp_id] = 1;
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (reroll[i]) begin
          reroll[i] = 0;
          wr_c[i] = 1'($urandom); a_c[i] = 6'($urandom); d_c[i] = 16'($urandom);
          set_req(i[0], 1'b1, wr_c[i], a_c[i], d_c[i]);
        end
      end
      if (n_acc >= 8) begin
        set_req(1'b0, 1'b0, 1'b0, 6'h0, 16'h0);
        set_req(1'b1, 1'b0, 1'b0, 6'h0, 16'h0);
        drain++;
      end
    end
    m_ready = 1'b0;
    n_checks++;
    if (n_acc != 8) begin n_fail++; $display("FAIL contention_count: got %0d accepts expected 8", n_acc); end
    n_checks++;
    if ({busy_acc, spurious} !== 2'b00) begin
      n_fail++; $display("FAIL contention_busy: accept_while_busy=%b spurious_rvalid=%b expected 0/0", busy_acc, spurious);
    end
  endtask

  task automatic test_slow_memory();
    logic [15:0] v = 16'($urandom);
    drive_txn(1'b0, 1'b0, 6'h3F, 16'hFFFF, v, 5);
    exp_last = 1'b0; exp_rd0 = v;
    n_checks++;
    if ({obs_acc, obs_stable, obs_mv, obs_mwr, obs_maddr, obs_mwd} !== {1'b1, 1'b1, 1'b1, 1'b0, 6'h3F, 16'h0}) begin
      n_fail++; $display("FAIL slow_issue_stable: got acc=%b stable=%b a=%h d=%h expected 1/1/3f/0000", obs_acc, obs_stable, obs_maddr, obs_mwd);
    end
    n_checks++;
    if ({obs_rv_issue, obs_rv1, obs_rv2, obs_err, obs_rd0, obs_rd1} !== {1'b0, 2'b01, 2'b00, 1'b0, exp_rd0, exp_rd1}) begin
      n_fail++; $display("FAIL slow_complete: rv=%b/%b err=%b rdata=%h/%h expected 01/00 0 %h/%h", obs_rv1, obs_rv2, obs_err, obs_rd0, obs_rd1, exp_rd0, exp_rd1);
    end
  endtask

  task automatic test_timeout();
    bit mv_ok = 1, err_early = 0, rv_seen = 0;
    set_req(1'b0, 1'b1, 1'b0, 6'h33, 16'h0);
    #1;
    n_checks++;
    if (r0_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_accept: r0_ready got %b expected 1", r0_ready); end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 6'h0, 16'h0);
    m_ready = 1'b0;
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      if (k == TIMEOUT + 1) set_req(1'b1, 1'b1, 1'b1, 6'h34, 16'h7777);
      #1;
      if (r0_rvalid || r1_rvalid) rv_seen = 1;
      if (k <= TIMEOUT) begin
        if (!m_valid) mv_ok = 0;
        if (err) err_early = 1;
      end else begin
        n_checks++;
        if ({err, m_valid, r1_ready} !== 3'b101) begin
          n_fail++; $display("FAIL timeout_abort: err/m_valid/r1_ready got %b%b%b expected 101", err, m_valid, r1_ready);
        end
      end
      @(posedge clk); #1;
    end
    exp_last = 1'b1;
    set_req(1'b1, 1'b0, 1'b0, 6'h0, 16'h0);
    #1;
    n_checks++;
    if ({err, m_valid, m_wr_rd, m_addr, m_wdata} !== {1'b0, 1'b1, 1'b1, 6'h34, 16'h7777}) begin
      n_fail++; $display("FAIL timeout_next: err=%b v=%b a=%h d=%h expected 0/1/34/7777", err, m_valid, m_addr, m_wdata);
    end
    n_checks++;
    if ({mv_ok, err_early, rv_seen} !== 3'b100) begin
      n_fail++; $display("FAIL timeout_wait: mv_held=%b early_err=%b rvalid=%b expected 1/0/0", mv_ok, err_early, rv_seen);
    end
    @(posedge clk); #1; m_ready = 1'b1;
    @(posedge clk); #1; m_ready = 1'b0;
    #1;
    n_checks++;
    if ({m_valid, r0_rdata, r1_rdata} !== {1'b0, exp_rd0, exp_rd1}) begin
      n_fail++; $display("FAIL timeout_rdata_kept: m_valid=%b rdata=%h/%h expected 0 %h/%h", m_valid, r0_rdata, r1_rdata, exp_rd0, exp_rd1);
    end
  endtask

  task automatic test_random();
    bit          id, wr;
    logic [5:0]  a;
    logic [15:0] wd, rd;
    int          lat;
    for (int i = 0; i < 64; i++) mem_model[i] = 16'($urandom);
    for (int n = 0; n < 16; n++) begin
      id = 1'($urandom); wr = 1'($urandom); a = 6'($urandom); wd = 16'($urandom);
      lat = int'($urandom_range(4, 1));
      rd = wr ? 16'($urandom) : mem_model[a];
      drive_txn(id, wr, a, wd, rd, lat);
      exp_last = id;
      if (wr) mem_model[a] = wd;
      else if (id) exp_rd1 = rd;
      else exp_rd0 = rd;
      n_checks++;
      if ({obs_acc, obs_stable, obs_mv, obs_mwr, obs_maddr, obs_mwd} !== {1'b1, 1'b1, 1'b1, wr, a, wr ? wd : 16'h0}) begin
        n_fail++; $display("FAIL random_issue_%0d: got acc=%b st=%b wr=%b a=%h d=%h expected wr=%b a=%h", n, obs_acc, obs_stable, obs_mwr, obs_maddr, obs_mwd, wr, a);
      end
      n_checks++;
      if ({obs_rv_issue, obs_rv1, obs_rv2, obs_err, obs_rd0, obs_rd1} !==
          {1'b0, wr ? 2'b00 : (id ? 2'b10 : 2'b01), 2'b00, 1'b0, exp_rd0, exp_rd1}) begin
        n_fail++; $display("FAIL random_resp_%0d: rv=%b err=%b rdata=%h/%h expected rdata %h/%h", n, obs_rv1, obs_err, obs_rd0, obs_rd1, exp_rd0, exp_rd1);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_ready = 1'b0; m_rdata = '0;
    set_req(1'b0, 1'b0, 1'b0, 6'h0, 16'h0);
    set_req(1'b1, 1'b0, 1'b0, 6'h0, 16'h0);
    rst = 1'b1;
    #2 rst = 1'b0;
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_slow_memory();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester front end for the single-port memory. Accepts read/write commands from two independent requesters over valid/ready handshakes, arbitrates round-robin, drives the memory's `wr_rd`/`addr`/`wdata`/`valid` interface one transaction at a time, and returns read data to the requester that issued the read. Sits directly between the requesters and the memory port; the memory sees exactly one master.

## Interface
- `ADDR_WIDTH`, 6: memory address width, matches memory `` `ADDR_WIDTH ``.
- `WIDTH`, 16: data width, matches memory `` `WIDTH ``.
- `TIMEOUT`, 15: maximum cycles `m_valid` may wait for `m_ready` before the transaction is aborted; must be ≥ 2.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rN_valid`  in  1  requester N (N = 0, 1) command valid.
- `rN_ready`  out  1  command accepted this cycle.
- `rN_wr_rd`  in  1  1 = write, 0 = read.
- `rN_addr`  in  ADDR_WIDTH  command address.
- `rN_wdata`  in  WIDTH  write data.
- `rN_rdata`  out  WIDTH  last read data returned to requester N.
- `rN_rvalid`  out  1  one-cycle pulse, `rN_rdata` updated.
- `m_valid`  out  1  memory request valid.
- `m_ready`  in  1  memory accepts/completes request.
- `m_wr_rd`  out  1  memory direction.
- `m_addr`  out  ADDR_WIDTH  memory address.
- `m_wdata`  out  WIDTH  memory write data.
- `m_rdata`  in  WIDTH  memory read data, valid in the `m_valid && m_ready` cycle of a read.
- `err`  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: `rN_ready = (state==IDLE) && grant==N && rN_valid` (combinational). Grant: only one valid → it wins; both valid → requester not granted last wins. `last` pointer resets to 1 (requester 0 wins first contest). On accept: latch wr_rd/addr/wdata and owner ID, update `last`, go ISSUE.
- ISSUE: `m_valid=1`, `m_wr_rd/m_addr` from latch; `m_wdata` = latched data on write, 0 on read. Held stable until `m_ready`. On `m_valid && m_ready`: write → IDLE; read → capture `m_rdata` into owner's `rN_rdata`, go RESP.
- RESP: owner's `rN_rvalid=1` for exactly one cycle, → IDLE. Non-owner `rN_rdata` unchanged.
- Timeout: wait counter cleared on entering ISSUE, incremented each ISSUE cycle without `m_ready`; reaching TIMEOUT → `err` pulse next cycle, → IDLE, no `rvalid`, `rN_rdata` unchanged.
- Outside ISSUE all `m_*` outputs drive 0. `m_ready` outside ISSUE is ignored.
- Requesters hold valid and command stable until ready; arbiter never accepts in ISSUE/RESP.

## Timing
- Reset (`rst`=0, async): state IDLE, all outputs 0, `rN_rdata`=0, counter 0, `last`=1. Reset mid-transaction drops it silently; no `rvalid`/`err`.
- Accept at cycle T → `m_valid` at T+1. Memory returns `m_ready` at T+2 earliest.
- Write with `m_ready` at T+2: IDLE at T+3, next accept at T+3.
- Read with `m_ready` at T+2: `rN_rvalid`/`rN_rdata` at T+3, next accept at T+4.
- Back-to-back contention: grants strictly alternate 0,1,0,1.
- Timeout with `m_ready` never asserting: `err` at T+1+TIMEOUT, IDLE same cycle.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE, ISSUE, RESP), requester-ID type, `NUM_REQ`=2 constant.
- One sub-module `mem_rr_pick`: combinational two-way round-robin pick from valid vector and `last` pointer → grant one-hot.

## Test plan
- Reset: drive `rst`=0 mid-ISSUE → all outputs 0 immediately; after release, simultaneous requests → r0 granted first.
- Single write: r0 write addr 0x05 data 0xBEEF, `m_ready` at T+2 → `m_valid`/`m_wr_rd`=1/`m_addr`=0x05/`m_wdata`=0xBEEF at T+1, `r0_rvalid` never pulses.
- Single read: r1 read addr 0x05, memory returns 0xBEEF → `r1_rdata`=0xBEEF, `r1_rvalid` 1 cycle at T+3, `m_wdata`=0, `r0_rdata` unchanged.
- Contention: both requesters continuously valid for 8 transactions → grant order 0,1,0,1,0,1,0,1; no accept while not IDLE.
- Slow memory: `m_ready` delayed 5 cycles → `m_*` stable through the wait, completion normal.
- Timeout: `m_ready` held 0 → `err` pulse at T+1+TIMEOUT, `m_valid` drops, next request accepted the following cycle.
